// File: rtl/uart_reg_bridge_if.sv
// uart_reg_bridge_if
// Groups the three byte/word channels that the UART register bridge sits
// between:
//   - receive byte stream from uart_rx   (uart_rx_data_i / _vld_i / _rdy_o)
//   - transmit byte stream to uart_tx    (uart_tx_data_o / _vld_o / _rdy_i)
//   - local 32-bit register bus          (reg_addr_o, reg_wr_data_o,
//                                         reg_wr_en_o, reg_rd_en_o,
//                                         reg_rd_data_i)
// Signal suffixes are named from the bridge's point of view.
// The slave modport is taken by the bridge; the master modport is taken by
// whatever drives the bridge (UART pair plus register file, or a bench).
interface uart_reg_bridge_if;
  logic [7:0]  uart_rx_data_i;
  logic        uart_rx_data_vld_i;
  logic        uart_rx_data_rdy_o;
  logic [7:0]  uart_tx_data_o;
  logic        uart_tx_data_vld_o;
  logic        uart_tx_data_rdy_i;
  logic [7:0]  reg_addr_o;
  logic [31:0] reg_wr_data_o;
  logic        reg_wr_en_o;
  logic        reg_rd_en_o;
  logic [31:0] reg_rd_data_i;

  modport slave (
    input  uart_rx_data_i, uart_rx_data_vld_i,
    output uart_rx_data_rdy_o,
    output uart_tx_data_o, uart_tx_data_vld_o,
    input  uart_tx_data_rdy_i,
    output reg_addr_o, reg_wr_data_o, reg_wr_en_o, reg_rd_en_o,
    input  reg_rd_data_i
  );

  modport master (
    output uart_rx_data_i, uart_rx_data_vld_i,
    input  uart_rx_data_rdy_o,
    input  uart_tx_data_o, uart_tx_data_vld_o,
    output uart_tx_data_rdy_i,
    input  reg_addr_o, reg_wr_data_o, reg_wr_en_o, reg_rd_en_o,
    output reg_rd_data_i
  );
endinterface

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge
// Device-side end of the host UART control protocol. Parses command frames
// from the receive byte stream, performs 32-bit register reads/writes on the
// local register bus and streams the response frame back out.
//   Requests : 'W' addr d3 d2 d1 d0   |   'R' addr
//   Responses: 'K'                    |   'D' d3 d2 d1 d0   |   'E' (bad cmd)
// Ports:
//   clk_i      - system clock
//   rst_n_i    - asynchronous active-low reset
//   bus        - slave side of uart_reg_bridge_if (rx bytes, tx bytes,
//                register bus)
//   cmd_err_o  - one-cycle pulse on an unknown command byte or a frame timeout
// Parameter:
//   TIMEOUT_CYCLES - idle cycles tolerated between bytes of a partial frame
module uart_reg_bridge #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  uart_reg_bridge_if.slave bus,
  output logic            cmd_err_o
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_OK    = 8'h4B;
  localparam logic [7:0] RSP_DATA  = 8'h44;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_WR,
    S_RD,
    S_RDW,
    S_RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        err_nxt;
  logic        started;
  logic        is_write;
  logic [7:0]  addr_q;
  logic [23:0] data_sr;
  logic [1:0]  data_cnt;
  logic [39:0] resp_sr;
  logic [2:0]  resp_cnt;
  logic [31:0] gap_cnt;
  logic        rx_rdy;
  logic        tx_vld;
  logic        rx_acc;
  logic        tx_acc;
  logic        in_frame;
  logic        timeout;

  // Receive is only open while collecting a frame. "started" keeps ready low
  // while reset is held and raises it on the first clock after release.
  assign rx_rdy   = started && (state == S_IDLE || state == S_ADDR || state == S_DATA);
  assign tx_vld   = (state == S_RESP);
  assign rx_acc   = bus.uart_rx_data_vld_i && rx_rdy;
  assign tx_acc   = tx_vld && bus.uart_tx_data_rdy_i;
  assign in_frame = (state == S_ADDR) || (state == S_DATA);

  // An accepted byte always beats the timeout in the same cycle.
  assign timeout  = in_frame && !rx_acc && (gap_cnt >= TIMEOUT_CYCLES - 32'd1);

  assign bus.uart_rx_data_rdy_o = rx_rdy;
  assign bus.uart_tx_data_vld_o = tx_vld;
  assign bus.uart_tx_data_o     = resp_sr[39:32];
  assign bus.reg_wr_en_o        = (state == S_WR);
  assign bus.reg_rd_en_o        = (state == S_RD);

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and error pulse request.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_acc) begin
          if (bus.uart_rx_data_i == CMD_WRITE || bus.uart_rx_data_i == CMD_READ) begin
            state_nxt = S_ADDR;
          end else begin
            state_nxt = S_RESP;
            err_nxt   = 1'b1;
          end
        end
      end
      S_ADDR: begin
        if (rx_acc) begin
          state_nxt = is_write ? S_DATA : S_RD;
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_DATA: begin
        if (rx_acc) begin
          if (data_cnt == 2'd3) begin
            state_nxt = S_WR;
          end
        end else if (timeout) begin
          state_nxt = S_IDLE;
          err_nxt   = 1'b1;
        end
      end
      S_WR:   state_nxt = S_RESP;
      S_RD:   state_nxt = S_RDW;
      S_RDW:  state_nxt = S_RESP;
      S_RESP: begin
        if (tx_acc && resp_cnt == 3'd1) begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Frame capture, register bus outputs, response shifter and gap counter.
  // The bus address/data are loaded only when a complete request is in hand,
  // so an abandoned frame never disturbs what the register bus last saw.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      started           <= 1'b0;
      cmd_err_o         <= 1'b0;
      is_write          <= 1'b0;
      addr_q            <= 8'h00;
      data_sr           <= 24'h0;
      data_cnt          <= 2'd0;
      resp_sr           <= 40'h0;
      resp_cnt          <= 3'd0;
      gap_cnt           <= 32'd0;
      bus.reg_addr_o    <= 8'h00;
      bus.reg_wr_data_o <= 32'h0;
    end else begin
      started   <= 1'b1;
      cmd_err_o <= err_nxt;

      if (in_frame && !rx_acc && !timeout) begin
        gap_cnt <= gap_cnt + 32'd1;
      end else begin
        gap_cnt <= 32'd0;
      end

      case (state)
        S_IDLE: begin
          if (rx_acc) begin
            is_write <= (bus.uart_rx_data_i == CMD_WRITE);
            data_cnt <= 2'd0;
            if (err_nxt) begin
              resp_sr  <= {RSP_ERR, 32'h0};
              resp_cnt <= 3'd1;
            end
          end
        end
        S_ADDR: begin
          if (rx_acc) begin
            addr_q <= bus.uart_rx_data_i;
            if (!is_write) begin
              bus.reg_addr_o <= bus.uart_rx_data_i;
            end
          end
        end
        S_DATA: begin
          if (rx_acc) begin
            data_sr  <= {data_sr[15:0], bus.uart_rx_data_i};
            data_cnt <= data_cnt + 2'd1;
            if (data_cnt == 2'd3) begin
              bus.reg_addr_o    <= addr_q;
              bus.reg_wr_data_o <= {data_sr, bus.uart_rx_data_i};
            end
          end
        end
        S_WR: begin
          resp_sr  <= {RSP_OK, 32'h0};
          resp_cnt <= 3'd1;
        end
        S_RDW: begin
          resp_sr  <= {RSP_DATA, bus.reg_rd_data_i};
          resp_cnt <= 3'd5;
        end
        S_RESP: begin
          if (tx_acc) begin
            resp_sr  <= {resp_sr[31:0], 8'h00};
            resp_cnt <= resp_cnt - 3'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_reg_bridge.sv
// tb_uart_reg_bridge
// Directed bench for uart_reg_bridge with a scoreboard: stimulus pushes the
// expected tx bytes, write strobes and error pulses into queues, and a
// monitor pops and compares them as the DUT produces them.
module tb_uart_reg_bridge;

  logic clk_i = 1'b0;
  logic rst_n_i;
  logic cmd_err_o;

  uart_reg_bridge_if bus();

  uart_reg_bridge #(.TIMEOUT_CYCLES(32'd100)) dut (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .bus       (bus.slave),
    .cmd_err_o (cmd_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0] data;
    int         lat;
    bit         last;
  } tx_exp_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  tx_exp_t     exp_tx[$];
  wr_exp_t     exp_wr[$];
  int          exp_err[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          tx_mode = 0;
  logic [31:0] mem [256];

  initial begin
    forever begin
      @(posedge clk_i);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic push_tx(input logic [7:0] d, input int lat, input bit last);
    tx_exp_t e;
    e.data = d;
    e.lat  = lat;
    e.last = last;
    exp_tx.push_back(e);
  endtask

  task automatic expect_write(input logic [7:0] a, input logic [31:0] d);
    wr_exp_t w;
    w.addr = a;
    w.data = d;
    exp_wr.push_back(w);
    push_tx(8'h4B, 2, 1'b1);
  endtask

  task automatic expect_read(input logic [7:0] b3, input logic [7:0] b2,
                             input logic [7:0] b1, input logic [7:0] b0);
    push_tx(8'h44, 3, 1'b0);
    push_tx(b3, 0, 1'b0);
    push_tx(b2, 0, 1'b0);
    push_tx(b1, 0, 1'b0);
    push_tx(b0, 0, 1'b1);
  endtask

  // Called on a falling edge; presents the byte until the DUT takes it.
  task automatic applyStimulus(input logic [7:0] b);
    int w;
    bus.uart_rx_data_i     = b;
    bus.uart_rx_data_vld_i = 1'b1;
    w = 0;
    while (!bus.uart_rx_data_rdy_o && w < 200) begin
      @(negedge clk_i);
      w++;
    end
    if (w >= 200) check("rx_accept_timeout", 64'd0, 64'd1);
    last_acc = cyc;
    @(negedge clk_i);
    bus.uart_rx_data_vld_i = 1'b0;
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((exp_tx.size() != 0 || exp_wr.size() != 0 || exp_err.size() != 0) && w < 400) begin
      @(negedge clk_i);
      w++;
    end
    if (w >= 400) check("drain_timeout", 64'd0, 64'd1);
    repeat (3) @(negedge clk_i);
  endtask

  task automatic checkOutput(input string tag);
    check({tag, "_rx_rdy"},  bus.uart_rx_data_rdy_o, 0);
    check({tag, "_tx_vld"},  bus.uart_tx_data_vld_o, 0);
    check({tag, "_tx_data"}, bus.uart_tx_data_o, 0);
    check({tag, "_wr_en"},   bus.reg_wr_en_o, 0);
    check({tag, "_rd_en"},   bus.reg_rd_en_o, 0);
    check({tag, "_addr"},    bus.reg_addr_o, 0);
    check({tag, "_wr_data"}, bus.reg_wr_data_o, 0);
    check({tag, "_cmd_err"}, cmd_err_o, 0);
  endtask

  // Called on a falling edge with rst_n_i high; asserts reset, checks every
  // output is cleared at once, discards pending expectations and releases.
  task automatic pulse_reset(input string tag);
    rst_n_i = 1'b0;
    bus.uart_rx_data_vld_i = 1'b0;
    #1;
    checkOutput(tag);
    exp_tx.delete();
    exp_wr.delete();
    exp_err.delete();
    repeat (3) @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    check({tag, "_rdy_before_clk"}, bus.uart_rx_data_rdy_o, 0);
    @(negedge clk_i);
    #1;
    check({tag, "_rdy_after_clk"}, bus.uart_rx_data_rdy_o, 1);
    @(negedge clk_i);
  endtask

  // Transmit ready pattern: 0 = always, 1 = one cycle in three, 2 = never.
  initial begin
    bus.uart_tx_data_rdy_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #2;
      case (tx_mode)
        0:       bus.uart_tx_data_rdy_i = 1'b1;
        1:       bus.uart_tx_data_rdy_i = (cyc % 3 == 0);
        default: bus.uart_tx_data_rdy_i = 1'b0;
      endcase
    end
  end

  // Register file model: writes land on the strobe, read data is driven
  // only for the single cycle after the read strobe.
  initial begin
    logic       rd_pend;
    logic [7:0] rd_addr;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[8'h22] = 32'h1234_5678;
    bus.reg_rd_data_i = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk_i);
      #1;
      rd_pend = bus.reg_rd_en_o;
      rd_addr = bus.reg_addr_o;
      if (bus.reg_wr_en_o) mem[bus.reg_addr_o] = bus.reg_wr_data_o;
      @(posedge clk_i);
      #1;
      bus.reg_rd_data_i = rd_pend ? mem[rd_addr] : 32'hBAD0_BAD0;
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic       prev_vld;
    logic       prev_rdy;
    logic [7:0] prev_data;
    int         tx_start;
    int         rdy_check_at;
    tx_exp_t    e;
    wr_exp_t    w;
    int         el;
    prev_vld = 1'b0;
    prev_rdy = 1'b0;
    prev_data = 8'h00;
    tx_start = 0;
    rdy_check_at = -1;
    forever begin
      @(negedge clk_i);
      #1;
      if (!rst_n_i) begin
        prev_vld = 1'b0;
        rdy_check_at = -1;
      end else begin
        check("strobe_excl", bus.reg_wr_en_o & bus.reg_rd_en_o, 0);
        if (bus.uart_tx_data_vld_o) check("rx_rdy_in_resp", bus.uart_rx_data_rdy_o, 0);
        if (bus.uart_tx_data_vld_o && !prev_vld) tx_start = cyc;
        if (prev_vld && !prev_rdy) begin
          check("tx_vld_hold", bus.uart_tx_data_vld_o, 1);
          check("tx_data_hold", bus.uart_tx_data_o, prev_data);
        end
        if (cyc == rdy_check_at) check("rx_rdy_after_resp", bus.uart_rx_data_rdy_o, 1);
        if (bus.uart_tx_data_vld_o && bus.uart_tx_data_rdy_i) begin
          if (exp_tx.size() == 0) begin
            check("tx_unexpected", bus.uart_tx_data_o, 9'h100);
          end else begin
            e = exp_tx.pop_front();
            check("tx_byte", bus.uart_tx_data_o, e.data);
            if (e.lat != 0) check("tx_latency", tx_start - last_acc, e.lat);
            if (e.last) rdy_check_at = cyc + 1;
          end
        end
        if (bus.reg_wr_en_o) begin
          if (exp_wr.size() == 0) begin
            check("wr_unexpected", bus.reg_wr_en_o, 0);
          end else begin
            w = exp_wr.pop_front();
            check("wr_addr", bus.reg_addr_o, w.addr);
            check("wr_data", bus.reg_wr_data_o, w.data);
            check("wr_latency", cyc - last_acc, 1);
          end
        end
        if (cmd_err_o) begin
          if (exp_err.size() == 0) begin
            check("err_unexpected", cmd_err_o, 0);
          end else begin
            el = exp_err.pop_front();
            check("err_latency", cyc - last_acc, el);
          end
        end
        prev_vld  = bus.uart_tx_data_vld_o;
        prev_rdy  = bus.uart_tx_data_rdy_i;
        prev_data = bus.uart_tx_data_o;
      end
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int wt;
    rst_n_i = 1'b0;
    bus.uart_rx_data_i = 8'h00;
    bus.uart_rx_data_vld_i = 1'b0;
    #1;
    checkOutput("reset");
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    #1;
    check("rdy_before_first_clk", bus.uart_rx_data_rdy_o, 0);
    @(negedge clk_i);
    #1;
    check("rdy_after_first_clk", bus.uart_rx_data_rdy_o, 1);
    @(negedge clk_i);

    $display("[TB] write 57 10 DE AD BE EF");
    expect_write(8'h10, 32'hDEAD_BEEF);
    applyStimulus(8'h57); applyStimulus(8'h10);
    applyStimulus(8'hDE); applyStimulus(8'hAD); applyStimulus(8'hBE); applyStimulus(8'hEF);
    wait_drain();

    $display("[TB] read 52 22");
    expect_read(8'h12, 8'h34, 8'h56, 8'h78);
    applyStimulus(8'h52); applyStimulus(8'h22);
    wait_drain();

    $display("[TB] read 52 10 with tx backpressure");
    tx_mode = 1;
    expect_read(8'hDE, 8'hAD, 8'hBE, 8'hEF);
    applyStimulus(8'h52); applyStimulus(8'h10);
    wait_drain();
    tx_mode = 0;
    repeat (2) @(negedge clk_i);

    $display("[TB] unknown command 41 then read");
    exp_err.push_back(1);
    push_tx(8'h45, 1, 1'b1);
    applyStimulus(8'h41);
    wait_drain();
    expect_read(8'h12, 8'h34, 8'h56, 8'h78);
    applyStimulus(8'h52); applyStimulus(8'h22);
    wait_drain();

    $display("[TB] timeout after 57 10 AA");
    exp_err.push_back(101);
    applyStimulus(8'h57); applyStimulus(8'h10); applyStimulus(8'hAA);
    wait_drain();
    repeat (10) @(negedge clk_i);
    expect_read(8'h12, 8'h34, 8'h56, 8'h78);
    applyStimulus(8'h52); applyStimulus(8'h22);
    wait_drain();

    $display("[TB] byte landing on the timeout cycle");
    expect_write(8'h10, 32'hAABB_CCDD);
    applyStimulus(8'h57); applyStimulus(8'h10); applyStimulus(8'hAA);
    repeat (99) @(negedge clk_i);
    applyStimulus(8'hBB); applyStimulus(8'hCC); applyStimulus(8'hDD);
    wait_drain();

    $display("[TB] reset during write data bytes");
    applyStimulus(8'h57); applyStimulus(8'h10); applyStimulus(8'h11);
    pulse_reset("rst_data");
    expect_read(8'h12, 8'h34, 8'h56, 8'h78);
    applyStimulus(8'h52); applyStimulus(8'h22);
    wait_drain();
    expect_read(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    applyStimulus(8'h52); applyStimulus(8'h10);
    wait_drain();

    $display("[TB] reset during read response");
    tx_mode = 2;
    applyStimulus(8'h52); applyStimulus(8'h22);
    wt = 0;
    while (!bus.uart_tx_data_vld_o && wt < 50) begin
      @(negedge clk_i);
      wt++;
    end
    check("resp_reached", bus.uart_tx_data_vld_o, 1);
    tx_mode = 0;
    pulse_reset("rst_resp");
    expect_read(8'h12, 8'h34, 8'h56, 8'h78);
    applyStimulus(8'h52); applyStimulus(8'h22);
    wait_drain();

    check("left_tx", exp_tx.size(), 0);
    check("left_wr", exp_wr.size(), 0);
    check("left_err", exp_err.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
